// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG entropy path: word width, default block
// geometry and health-test limit, and the collector state encoding.
package trng_pkg;

    localparam int ENTROPY_WORD_WIDTH = 32;
    localparam int DEFAULT_NUM_WORDS  = 16;
    localparam int DEFAULT_REP_LIMIT  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2,
        ST_ERROR   = 2'd3
    } collector_state_t;

endpackage

// File: rtl/entropy_rep_test.sv
// Repetition-count health test. Tracks the previous captured word and how
// many consecutive captures have matched it; fail pulses combinationally on
// the capture that brings the run length up to REP_LIMIT.
module entropy_rep_test
    import trng_pkg::*;
#(
    parameter int REP_LIMIT = DEFAULT_REP_LIMIT
)
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          capture,
    input  logic [ENTROPY_WORD_WIDTH-1:0] word,
    input  logic                          clear,
    output logic                          fail
);

    logic [ENTROPY_WORD_WIDTH-1:0] prev_word_reg;
    logic                          prev_valid_reg;
    logic [7:0]                    rep_count_reg;
    logic [7:0]                    rep_count_next;
    logic                          repeat_hit;

    // A word only counts as a repeat if there is a valid predecessor to match.
    assign repeat_hit = prev_valid_reg && (word == prev_word_reg);

    // Run length after this capture; a fresh value always starts a run of 1.
    // The count cannot wrap: reaching REP_LIMIT (<= 255) stops further captures.
    always_comb begin
        rep_count_next = 8'd1;
        if (repeat_hit) begin
            rep_count_next = rep_count_reg + 8'd1;
        end
    end

    assign fail = capture && (rep_count_next == 8'(REP_LIMIT));

    // Previous-word and run-length state; clear takes priority over capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_word_reg  <= '0;
            prev_valid_reg <= 1'b0;
            rep_count_reg  <= '0;
        end else if (clear) begin
            prev_valid_reg <= 1'b0;
            rep_count_reg  <= '0;
        end else if (capture) begin
            prev_word_reg  <= word;
            prev_valid_reg <= 1'b1;
            rep_count_reg  <= rep_count_next;
        end
    end

endmodule

// File: rtl/entropy_collector.sv
// Entropy collector: consumes words from one entropy source over a
// valid/ack handshake, packs NUM_WORDS of them into a block (word 0 in the
// MSBs) for the mixer, and latches a sticky security_error when the
// repetition-count health test trips.
module entropy_collector
    import trng_pkg::*;
#(
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int REP_LIMIT = DEFAULT_REP_LIMIT
)
(
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    enable,
    input  logic                                    entropy_enabled,
    input  logic [ENTROPY_WORD_WIDTH-1:0]           entropy_data,
    input  logic                                    entropy_valid,
    output logic                                    entropy_ack,
    output logic [NUM_WORDS*ENTROPY_WORD_WIDTH-1:0] block_data,
    output logic                                    block_valid,
    input  logic                                    block_ack,
    input  logic                                    clear_error,
    output logic                                    security_error
);

    localparam int W     = ENTROPY_WORD_WIDTH;
    localparam int CNT_W = $clog2(NUM_WORDS + 1);

    collector_state_t state_reg;
    logic [CNT_W-1:0] word_count_reg;
    logic             ack_reg;
    logic             block_valid_reg;
    logic             security_error_reg;
    logic [W-1:0]     slot_reg [NUM_WORDS];

    logic run;
    logic capture;
    logic rep_fail;
    logic rep_clear;

    assign run = enable && entropy_enabled;

    // Valid is ignored during the ack cycle, and a disabling cycle captures
    // nothing so the held source word lands at slot 0 after re-enable.
    assign capture = (state_reg == ST_COLLECT) && run && entropy_valid && !ack_reg;

    // Health state is dropped whenever collection is abandoned or an error cleared.
    assign rep_clear = (((state_reg == ST_COLLECT) || (state_reg == ST_FULL)) && !run) ||
                       ((state_reg == ST_ERROR) && clear_error);

    entropy_rep_test #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_test (
        .clk     (clk),
        .reset_n (reset_n),
        .capture (capture),
        .word    (entropy_data),
        .clear   (rep_clear),
        .fail    (rep_fail)
    );

    // One block slot per word; slot gi sits at the gi-th word from the MSB end.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_slot
            // Load this slot when the capture targets it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    slot_reg[gi] <= '0;
                end else if (capture && (word_count_reg == CNT_W'(gi))) begin
                    slot_reg[gi] <= entropy_data;
                end
            end
            assign block_data[(NUM_WORDS-gi)*W-1 -: W] = slot_reg[gi];
        end
    endgenerate

    assign entropy_ack    = ack_reg;
    assign block_valid    = block_valid_reg;
    assign security_error = security_error_reg;

    // Collector FSM with word counter and registered ack/valid/error outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            word_count_reg     <= '0;
            ack_reg            <= 1'b0;
            block_valid_reg    <= 1'b0;
            security_error_reg <= 1'b0;
        end else begin
            ack_reg <= capture;
            case (state_reg)
                ST_IDLE: begin
                    word_count_reg  <= '0;
                    block_valid_reg <= 1'b0;
                    if (run) begin
                        state_reg <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!run) begin
                        state_reg      <= ST_IDLE;
                        word_count_reg <= '0;
                    end else if (capture) begin
                        if (rep_fail) begin
                            // Health failure outranks completing the block.
                            state_reg          <= ST_ERROR;
                            security_error_reg <= 1'b1;
                            word_count_reg     <= '0;
                        end else begin
                            word_count_reg <= word_count_reg + 1'b1;
                            if (word_count_reg == CNT_W'(NUM_WORDS - 1)) begin
                                state_reg       <= ST_FULL;
                                block_valid_reg <= 1'b1;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (!run) begin
                        state_reg       <= ST_IDLE;
                        word_count_reg  <= '0;
                        block_valid_reg <= 1'b0;
                    end else if (block_ack) begin
                        state_reg       <= ST_COLLECT;
                        word_count_reg  <= '0;
                        block_valid_reg <= 1'b0;
                    end
                end
                ST_ERROR: begin
                    word_count_reg  <= '0;
                    block_valid_reg <= 1'b0;
                    if (clear_error) begin
                        state_reg          <= ST_IDLE;
                        security_error_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_collector.sv
// Bench for entropy_collector: a queue-driven source model, a block
// scoreboard (expected blocks queued with the stimulus, compared when
// block_valid rises) and directed handshake/health/reset scenarios.
module tb_entropy_collector;

    localparam int NW = 16;
    localparam int BW = NW * 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          entropy_enabled;
    logic [31:0]   entropy_data;
    logic          entropy_valid;
    logic          entropy_ack;
    logic [BW-1:0] block_data;
    logic          block_valid;
    logic          block_ack;
    logic          clear_error;
    logic          security_error;

    entropy_collector #(.NUM_WORDS(NW), .REP_LIMIT(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .entropy_enabled (entropy_enabled),
        .entropy_data    (entropy_data),
        .entropy_valid   (entropy_valid),
        .entropy_ack     (entropy_ack),
        .block_data      (block_data),
        .block_valid     (block_valid),
        .block_ack       (block_ack),
        .clear_error     (clear_error),
        .security_error  (security_error)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            ack_cnt = 0;
    int            blk_cnt = 0;
    int            double_ack = 0;
    logic          ack_prev = 1'b0;
    logic          bv_prev = 1'b0;
    logic [31:0]   src_q[$];
    logic [BW-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        entropy_valid = (src_q.size() > 0);
        entropy_data  = (src_q.size() > 0) ? src_q[0] : 32'h0;
    endtask

    // Advance one clock, sample outputs 1 time unit after the edge, run the
    // source model and the block scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (entropy_ack) begin
            ack_cnt++;
            if (ack_prev) double_ack++;
            if (src_q.size() > 0) void'(src_q.pop_front());
        end
        ack_prev = entropy_ack;
        if (block_valid && !bv_prev) begin
            blk_cnt++;
            if (exp_q.size() == 0) begin
                check_val("blk_unexpected", BW'(1), BW'(0));
            end else begin
                check_val("blk_data", block_data, exp_q.pop_front());
            end
            $display("block %0d received", blk_cnt);
        end
        bv_prev = block_valid;
        drive_src();
    endtask

    task automatic wait_block(input int budget, output int n);
        n = 0;
        while (!block_valid && n < budget) begin
            tick();
            n++;
        end
        if (!block_valid) check_val("blk_timeout", BW'(0), BW'(1));
    endtask

    task automatic ack_block();
        block_ack = 1'b1;
        tick();
        block_ack = 1'b0;
        check_val("bv_after_ack", BW'(block_valid), BW'(0));
    endtask

    // Queue words to the source and the block they should form to the scoreboard.
    task automatic push_block(input logic [31:0] base);
        logic [BW-1:0] blk;
        blk = '0;
        for (int i = 0; i < NW; i++) begin
            src_q.push_back(base + 32'(i));
            blk = {blk[BW-33:0], base + 32'(i)};
        end
        exp_q.push_back(blk);
    endtask

    initial begin
        int            n;
        int            base_ack;
        logic [BW-1:0] saved;
        logic [BW-1:0] blk;

        reset_n = 1'b0; enable = 1'b0; entropy_enabled = 1'b1;
        block_ack = 1'b0; clear_error = 1'b0;
        drive_src();
        #12;
        check_val("rst_ack", BW'(entropy_ack), BW'(0));
        check_val("rst_bv", BW'(block_valid), BW'(0));
        check_val("rst_err", BW'(security_error), BW'(0));
        check_val("rst_data", block_data, BW'(0));
        reset_n = 1'b1;
        tick();

        // Normal block: words 1..16, block_valid 32 edges after enable.
        push_block(32'h1);
        drive_src();
        enable = 1'b1;
        wait_block(200, n);
        check_val("latency", BW'(n), BW'(32));
        check_val("ack_count", BW'(ack_cnt), BW'(16));

        // Backpressure: source stays valid while the full block waits.
        push_block(32'h101);
        saved = block_data;
        base_ack = ack_cnt;
        for (int i = 0; i < 50; i++) tick();
        check_val("bp_acks", BW'(ack_cnt), BW'(base_ack));
        check_val("bp_data", block_data, saved);
        check_val("bp_valid", BW'(block_valid), BW'(1));
        ack_block();
        wait_block(200, n);
        check_val("bp_resume_acks", BW'(ack_cnt), BW'(base_ack + 16));
        ack_block();

        // Disable mid-block: 5 words taken, then 1 cycle disabled; the 6th starts a new block.
        base_ack = ack_cnt;
        for (int i = 0; i < 5; i++) src_q.push_back(32'h201 + 32'(i));
        push_block(32'h206);
        n = 0;
        while (ack_cnt < base_ack + 5 && n < 100) begin tick(); n++; end
        check_val("dis_5acks", BW'(ack_cnt), BW'(base_ack + 5));
        enable = 1'b0;
        tick();
        enable = 1'b1;
        wait_block(200, n);
        check_val("dis_acks", BW'(ack_cnt), BW'(base_ack + 21));
        ack_block();

        // Stuck source: 8 identical captures trip the health test.
        base_ack = ack_cnt;
        for (int i = 0; i < 40; i++) src_q.push_back(32'h11223344);
        drive_src();
        n = 0;
        while (!security_error && n < 100) begin tick(); n++; end
        check_val("stuck_err", BW'(security_error), BW'(1));
        check_val("stuck_acks", BW'(ack_cnt), BW'(base_ack + 8));
        for (int i = 0; i < 20; i++) tick();
        check_val("err_no_acks", BW'(ack_cnt), BW'(base_ack + 8));
        check_val("err_bv", BW'(block_valid), BW'(0));
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check_val("err_cleared", BW'(security_error), BW'(0));
        n = 0;
        while (!security_error && n < 100) begin tick(); n++; end
        check_val("stuck_err2", BW'(security_error), BW'(1));
        check_val("stuck_acks2", BW'(ack_cnt), BW'(base_ack + 16));

        // Async reset in the ack cycle of the triggering capture.
        check_val("pre_rst_ack", BW'(entropy_ack), BW'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_ack", BW'(entropy_ack), BW'(0));
        check_val("arst_bv", BW'(block_valid), BW'(0));
        check_val("arst_err", BW'(security_error), BW'(0));
        ack_prev = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_val("idle_no_ack", BW'(entropy_ack), BW'(0));
        tick();
        check_val("first_ack", BW'(entropy_ack), BW'(1));
        enable = 1'b0;
        src_q.delete();
        tick();
        tick();

        // Alternating data: 4 blocks, no health failure.
        blk = '0;
        for (int i = 0; i < NW; i++) blk = {blk[BW-33:0], (i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A};
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NW; i++) src_q.push_back((i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A);
            exp_q.push_back(blk);
        end
        base_ack = blk_cnt;
        drive_src();
        enable = 1'b1;
        for (int b = 0; b < 4; b++) begin
            wait_block(200, n);
            ack_block();
        end
        check_val("alt_blocks", BW'(blk_cnt), BW'(base_ack + 4));
        check_val("alt_err", BW'(security_error), BW'(0));
        check_val("double_ack", BW'(double_ack), BW'(0));
        check_val("exp_drained", BW'(exp_q.size()), BW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
